asic_iocfg_seq: RTL
===================

Name: asic_iocfg_seq

Overview:
- Drives the TECH_CFG_WIDTH-bit tech_cfg control word of NPADS sky130 gpiov2 IO buffers; this block is the controller side of that bus.
- Runs the pad power-up, hold and power-down sequence (ENABLE_H, HLD_H_N).
- Translates generic 8-bit per-pad cfg (pull, slew, schmitt, drive strength) into pad-native DM/SLOW/VTRIP_SEL bits.
- Applies cfg changes glitch-free by holding pad state while new settings settle.
- Sits in the padring top, between the SoC control logic and the pad instances.

Parameters:
NPADS, 8, number of pads driven.
TECH_CFG_WIDTH, 16, per-pad tech_cfg width; only 16 supported.
T_EN, 16, cycles ENABLE_H is high before cfg load (>=1).
T_HOLD, 4, cycles HLD_H_N stays low around a cfg load or drain (>=1).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  level; 1 = power pads up, 0 = power down
upd  input  1  pulse; request to apply current cfg; honoured only when ready=1
cfg  input  NPADS*8  per-pad generic config; pad i uses bits [8i+7:8i]
tech_cfg  output  NPADS*TECH_CFG_WIDTH  per-pad pad control; pad i uses bits [16i+15:16i]
ready  output  1  1 only in RUN
busy  output  1  1 in every state except OFF and RUN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=OFF, timer=0, cfg_q=0, tech_cfg all zero, ready=0, busy=0. All outputs are registered.

States and transitions (timer loads N-1 on state entry; state lasts exactly N cycles):
- OFF: en=1 sampled -> EN.
- EN (T_EN cycles): en=0 -> OFF immediately; at timeout -> LOAD.
- LOAD (T_HOLD cycles): cfg captured into cfg_q on the entry cycle only. en=0 -> OFF immediately; at timeout -> RUN.
- RUN: en=0 -> DRAIN; else upd=1 -> UPD.
- UPD (T_HOLD cycles): en=0 -> DRAIN; at timeout -> LOAD.
- DRAIN (T_HOLD cycles): en is ignored; at timeout -> OFF. A later en=1 in OFF restarts the sequence.
- Simultaneous en=0 and upd=1 in RUN: en wins, go to DRAIN.
- upd outside RUN is dropped, not queued.

Per-pad tech_cfg fields (bit: value):
- 1 ENABLE_H: 1 in all states except OFF.
- 3 ENABLE_VDDA_H: equals ENABLE_H.
- 5 ENABLE_VDDIO: equals ENABLE_H.
- 0 HLD_H_N: 1 only in RUN.
- 2 ENABLE_INP_H, 4 ENABLE_VSWITCH_H, 6 IB_MODE_SEL, 9 HLD_OVR, 10-12 ANALOG_EN/SEL/POL: always 0.
- 8 SLOW: cfg_q[2], in non-OFF states.
- 7 VTRIP_SEL: ~cfg_q[3] (schmitt on -> CMOS trip), in non-OFF states.
- 15:13 DM, in non-OFF states, first match wins:
  - pe=cfg_q[0]=1 and ps=cfg_q[1]=1 -> 011
  - pe=1, ps=0 -> 010
  - pe=0 and ds=cfg_q[7:4] >= 8 -> 101
  - otherwise -> 110
- OFF: whole word is 0.

Timing:
- ready rises exactly T_EN+T_HOLD+1 cycles after the cycle en=1 is sampled in OFF.
- After an upd accepted in RUN, ready returns 2*T_HOLD+1 cycles later.
- ready=0 and HLD_H_N=0 on the cycle after en=0 is sampled in RUN.
- cfg changes outside LOAD entry have no effect on tech_cfg.

Test Plan:
- T_EN=4, T_HOLD=2, cfg pad0=0x00; rst, then en=1 -> ENABLE_H=1 next cycle; HLD_H_N=0 for 6 cycles; ready=1 and HLD_H_N=1 at cycle 7; pad0 DM=110, SLOW=0, VTRIP_SEL=1.
- DM mapping in RUN via upd, per pad: cfg 0x03 -> DM=011; 0x01 -> DM=010; 0x80 -> DM=101; 0x70 -> DM=110; 0x0C -> SLOW=1, VTRIP_SEL=0.
- In RUN change cfg without upd -> tech_cfg unchanged; pulse upd -> HLD_H_N=0 for 4 cycles, busy=1, new DM visible from LOAD entry+1, ready=1 after 5 cycles.
- en=0 in RUN -> DRAIN: HLD_H_N=0, ENABLE_H=1 for 2 cycles, then tech_cfg=0, busy=0; en=1 pulses during DRAIN ignored.
- en=0 mid-EN -> OFF next cycle, tech_cfg=0; en=0 together with upd=1 in RUN -> DRAIN, not UPD.
- rst asserted mid-UPD -> next cycle all outputs zero, state OFF; upd while busy=1 ignored.

Source files
------------

// File: rtl/asic_iocfg_seq.sv
// Power-up/hold/power-down sequencer for sky130 gpiov2 pads: drives the per-pad
// tech_cfg word and maps generic 8-bit pad cfg onto DM/SLOW/VTRIP_SEL.
module asic_iocfg_seq #(
    parameter int NPADS          = 8,
    parameter int TECH_CFG_WIDTH = 16,
    parameter int T_EN           = 16,
    parameter int T_HOLD         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              upd,
    input  logic [NPADS*8-1:0]                cfg,
    output logic [NPADS*TECH_CFG_WIDTH-1:0]   tech_cfg,
    output logic                              ready,
    output logic                              busy
);

    localparam int TMAX = (T_EN > T_HOLD) ? T_EN : T_HOLD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] EN_LOAD   = TW'(T_EN - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(T_HOLD - 1);

    typedef enum logic [2:0] {
        S_OFF, S_EN, S_LOAD, S_RUN, S_UPD, S_DRAIN
    } state_t;

    state_t                             state_q, state_d;
    logic [TW-1:0]                      timer_q, timer_d;
    logic [NPADS*8-1:0]                 cfg_q, cfg_d;
    logic [NPADS*TECH_CFG_WIDTH-1:0]    tech_d;
    logic                               ready_d, busy_d;

    function automatic logic [15:0] pad_word(input logic [7:0] c, input state_t s);
        logic [15:0] w;
        w = '0;
        if (s != S_OFF) begin
            w[0] = (s == S_RUN);
            w[1] = 1'b1;
            w[3] = 1'b1;
            w[5] = 1'b1;
            w[7] = ~c[3];
            w[8] = c[2];
            if (c[0] && c[1])       w[15:13] = 3'b011;
            else if (c[0])          w[15:13] = 3'b010;
            else if (c[7:4] >= 4'd8) w[15:13] = 3'b101;
            else                    w[15:13] = 3'b110;
        end
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
        cfg_d   = cfg_q;
        case (state_q)
            S_OFF: begin
                timer_d = '0;
                if (en) begin
                    state_d = S_EN;
                    timer_d = EN_LOAD;
                end
            end
            S_EN: begin
                if (!en) begin
                    state_d = S_OFF;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = S_LOAD;
                    timer_d = HOLD_LOAD;
                end
            end
            S_LOAD: begin
                // Timer still at its load value marks the first LOAD cycle.
                if (timer_q == HOLD_LOAD) cfg_d = cfg;
                if (!en) begin
                    state_d = S_OFF;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!en) begin
                    state_d = S_DRAIN;
                    timer_d = HOLD_LOAD;
                end else if (upd) begin
                    state_d = S_UPD;
                    timer_d = HOLD_LOAD;
                end
            end
            S_UPD: begin
                if (!en) begin
                    state_d = S_DRAIN;
                    timer_d = HOLD_LOAD;
                end else if (timer_q == '0) begin
                    state_d = S_LOAD;
                    timer_d = HOLD_LOAD;
                end
            end
            S_DRAIN: begin
                if (timer_q == '0) state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
                timer_d = '0;
            end
        endcase

        // Outputs are derived from next state so the registered values track the state register.
        tech_d = '0;
        for (int unsigned p = 0; p < NPADS; p++) begin
            tech_d[p*TECH_CFG_WIDTH +: 16] = pad_word(cfg_d[p*8 +: 8], state_d);
        end
        ready_d = (state_d == S_RUN);
        busy_d  = (state_d != S_OFF) && (state_d != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            timer_q  <= '0;
            cfg_q    <= '0;
            tech_cfg <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cfg_q    <= cfg_d;
            tech_cfg <= tech_d;
            ready    <= ready_d;
            busy     <= busy_d;
        end
    end

endmodule
